fft4_sched: RTL and testbench

Controller for a 4-point radix-2 decimation-in-time FFT. It accepts a serial stream of complex samples over a valid/ready handshake and buffers one 4-sample frame in bit-reversed order. It then sequences the butterfly passes over a single shared butterfly unit and streams the spectrum out in natural order. It sits between the sample source and the downstream spectral consumer, and replaces a single-cycle all-at-once FFT datapath with a frame-based schedule.

---
 rtl/fft_pkg.sv | 45 ++++
 rtl/fft_bfly.sv | 54 +++++
 rtl/fft4_sched.sv | 159 +++++++++++++++
 tb/tb_fft4_sched.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared types and helpers for the 4-point radix-2 DIT FFT controller.
package fft_pkg;

  localparam int unsigned N     = 4;
  localparam int unsigned LOG2N = 2;

  typedef logic [LOG2N-1:0] idx_t;

  typedef enum logic [1:0] {
    LOAD    = 2'd0,
    COMPUTE = 2'd1,
    UNLOAD  = 2'd2
  } state_e;

  // Twiddle select: W0 = 1, W1 = -j
  typedef enum logic {
    TW_W0 = 1'b0,
    TW_W1 = 1'b1
  } tw_e;

  // One butterfly operation: buffer addresses of a and b plus twiddle
  typedef struct packed {
    idx_t ia;
    idx_t ib;
    tw_e  tw;
  } bf_op_t;

  function automatic idx_t bitrev2(input idx_t n);
    return {n[0], n[1]};
  endfunction

  // Butterfly schedule: two stage-0 pairs, then the two stage-1 pairs
  function automatic bf_op_t bf_sched(input idx_t step);
    bf_op_t op;
    op = '0;
    case (step)
      2'd0: begin op.ia = 2'd0; op.ib = 2'd1; op.tw = TW_W0; end
      2'd1: begin op.ia = 2'd2; op.ib = 2'd3; op.tw = TW_W0; end
      2'd2: begin op.ia = 2'd0; op.ib = 2'd2; op.tw = TW_W0; end
      default: begin op.ia = 2'd1; op.ib = 2'd3; op.tw = TW_W1; end
    endcase
    return op;
  endfunction

endpackage

// File: rtl/fft_bfly.sv
// Combinational radix-2 butterfly with W0/-j twiddle; FFT_SCALE_EN halves
// each output (floor) so a stage can never overflow.
module fft_bfly
  import fft_pkg::*;
#(
  parameter int unsigned DW = 16
) (
  input  logic signed [DW-1:0] a_re,
  input  logic signed [DW-1:0] a_im,
  input  logic signed [DW-1:0] b_re,
  input  logic signed [DW-1:0] b_im,
  input  tw_e                  tw,
  output logic signed [DW-1:0] ap_re_c,
  output logic signed [DW-1:0] ap_im_c,
  output logic signed [DW-1:0] bp_re_c,
  output logic signed [DW-1:0] bp_im_c
);

  // Two guard bits: one for negating the most negative value, one for the sum
  localparam int unsigned EW = DW + 2;

  logic signed [EW-1:0] a_re_e, a_im_e;
  logic signed [EW-1:0] wb_re_e, wb_im_e;
  logic signed [EW-1:0] sum_re, sum_im, dif_re, dif_im;

  always_comb begin
    a_re_e = EW'(a_re);
    a_im_e = EW'(a_im);
    // Multiply by -j is a swap plus negate: (re, im) -> (im, -re)
    if (tw == TW_W1) begin
      wb_re_e = EW'(b_im);
      wb_im_e = -EW'(b_re);
    end else begin
      wb_re_e = EW'(b_re);
      wb_im_e = EW'(b_im);
    end
    sum_re = a_re_e + wb_re_e;
    sum_im = a_im_e + wb_im_e;
    dif_re = a_re_e - wb_re_e;
    dif_im = a_im_e - wb_im_e;
`ifdef FFT_SCALE_EN
    ap_re_c = DW'(sum_re >>> 1);
    ap_im_c = DW'(sum_im >>> 1);
    bp_re_c = DW'(dif_re >>> 1);
    bp_im_c = DW'(dif_im >>> 1);
`else
    ap_re_c = DW'(sum_re);
    ap_im_c = DW'(sum_im);
    bp_re_c = DW'(dif_re);
    bp_im_c = DW'(dif_im);
`endif
  end

endmodule

// File: rtl/fft4_sched.sv
// Frame-based 4-point FFT controller: load in bit-reversed order, four
// in-place butterflies on one shared unit, unload in natural order.
// Optional build macro: FFT_SCALE_EN (1/2 scaling per stage).
module fft4_sched
  import fft_pkg::*;
#(
  parameter int unsigned DW = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic signed [DW-1:0] in_real,
  input  logic signed [DW-1:0] in_imag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic signed [DW-1:0] out_real,
  output logic signed [DW-1:0] out_imag,
  output logic                 out_last,
  output logic                 busy
);

  state_e state_q, state_d;
  idx_t   cnt_q, cnt_d;

  logic signed [DW-1:0] buf_re_q [N];
  logic signed [DW-1:0] buf_im_q [N];
  logic signed [DW-1:0] buf_re_d [N];
  logic signed [DW-1:0] buf_im_d [N];

  logic                 in_ready_q, in_ready_d;
  logic                 busy_q, busy_d;
  logic                 out_valid_q, out_valid_d;
  logic                 out_last_q, out_last_d;
  logic signed [DW-1:0] out_real_q, out_real_d;
  logic signed [DW-1:0] out_imag_q, out_imag_d;

  bf_op_t               op;
  logic signed [DW-1:0] a_re, a_im, b_re, b_im;
  logic signed [DW-1:0] ap_re, ap_im, bp_re, bp_im;
  logic                 in_fire, out_fire;

  // in_ready is forced low for as long as reset is held
  assign in_ready  = in_ready_q && !reset;
  assign busy      = busy_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign out_real  = out_real_q;
  assign out_imag  = out_imag_q;

  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid_q && out_ready;

  // Operand fetch for the butterfly scheduled at the current step
  always_comb begin
    op   = bf_sched(cnt_q);
    a_re = buf_re_q[op.ia];
    a_im = buf_im_q[op.ia];
    b_re = buf_re_q[op.ib];
    b_im = buf_im_q[op.ib];
  end

  fft_bfly #(.DW(DW)) u_bfly (
    .a_re    (a_re),
    .a_im    (a_im),
    .b_re    (b_re),
    .b_im    (b_im),
    .tw      (op.tw),
    .ap_re_c (ap_re),
    .ap_im_c (ap_im),
    .bp_re_c (bp_re),
    .bp_im_c (bp_im)
  );

  // Next state, counter, buffer writes and registered outputs
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    buf_re_d = buf_re_q;
    buf_im_d = buf_im_q;

    case (state_q)
      LOAD: begin
        if (in_fire) begin
          buf_re_d[bitrev2(cnt_q)] = in_real;
          buf_im_d[bitrev2(cnt_q)] = in_imag;
          cnt_d = cnt_q + idx_t'(1);
          if (cnt_q == idx_t'(N - 1)) begin
            state_d = COMPUTE;
          end
        end
      end
      COMPUTE: begin
        buf_re_d[op.ia] = ap_re;
        buf_im_d[op.ia] = ap_im;
        buf_re_d[op.ib] = bp_re;
        buf_im_d[op.ib] = bp_im;
        cnt_d = cnt_q + idx_t'(1);
        if (cnt_q == idx_t'(N - 1)) begin
          state_d = UNLOAD;
        end
      end
      UNLOAD: begin
        if (out_fire) begin
          cnt_d = cnt_q + idx_t'(1);
          if (cnt_q == idx_t'(N - 1)) begin
            state_d = LOAD;
          end
        end
      end
      default: begin
        state_d = LOAD;
        cnt_d   = '0;
      end
    endcase

    // Output registers track the post-edge state so out_* hold under stall
    in_ready_d  = (state_d == LOAD);
    busy_d      = (state_d != LOAD);
    out_valid_d = (state_d == UNLOAD);
    out_last_d  = (state_d == UNLOAD) && (cnt_d == idx_t'(N - 1));
    if (state_d == UNLOAD) begin
      out_real_d = buf_re_d[cnt_d];
      out_imag_d = buf_im_d[cnt_d];
    end else begin
      out_real_d = '0;
      out_imag_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= LOAD;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_real_q  <= '0;
      out_imag_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_real_q  <= out_real_d;
      out_imag_q  <= out_imag_d;
    end
  end

  // Buffer needs no reset: every entry is rewritten during LOAD
  always_ff @(posedge clk) begin
    buf_re_q <= buf_re_d;
    buf_im_q <= buf_im_d;
  end

endmodule

// File: tb/tb_fft4_sched.sv
// Scoreboard bench for fft4_sched: expected bins are queued as frames are
// driven and checked as the DUT hands them out.
module tb_fft4_sched;

  localparam int unsigned DW = 16;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 in_valid;
  logic                 in_ready;
  logic signed [DW-1:0] in_real, in_imag;
  logic                 out_valid;
  logic                 out_ready;
  logic signed [DW-1:0] out_real, out_imag;
  logic                 out_last;
  logic                 busy;

  typedef struct {
    logic signed [15:0] re;
    logic signed [15:0] im;
    logic               last;
  } bin_t;

  bin_t sb[$];
  int   vectors     = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  fft4_sched #(.DW(DW)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_real   (in_real),
    .in_imag   (in_imag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_real  (out_real),
    .out_imag  (out_imag),
    .out_last  (out_last),
    .busy      (busy)
  );

  task automatic push_exp(input int re, input int im, input logic last);
    bin_t b;
    b.re   = 16'(re);
    b.im   = 16'(im);
    b.last = last;
    sb.push_back(b);
  endtask

  // Direct 4-point DFT with W = -j, reduced modulo 2^16
  task automatic push_dft(input int xr [4], input int xi [4]);
    for (int k = 0; k < 4; k++) begin
      int ar = 0;
      int ai = 0;
      for (int n = 0; n < 4; n++) begin
        case ((n * k) % 4)
          0: begin ar += xr[n]; ai += xi[n]; end
          1: begin ar += xi[n]; ai -= xr[n]; end
          2: begin ar -= xr[n]; ai -= xi[n]; end
          default: begin ar -= xi[n]; ai += xr[n]; end
        endcase
      end
      push_exp(ar, ai, k == 3);
    end
  endtask

  task automatic push_ramp_expected();
`ifdef FFT_SCALE_EN
    push_exp(2, 0, 1'b0);
    push_exp(-1, 0, 1'b0);
    push_exp(-1, 0, 1'b0);
    push_exp(-1, -1, 1'b1);
`else
    push_exp(10, 0, 1'b0);
    push_exp(-2, 2, 1'b0);
    push_exp(-2, 0, 1'b0);
    push_exp(-2, -2, 1'b1);
`endif
  endtask

  task automatic send_frame(input int xr [4], input int xi [4]);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_real  = 16'(xr[i]);
      in_imag  = 16'(xi[i]);
      vectors++;
      if (in_ready !== 1'b1) begin
        miscompares++;
        $display("FAIL load_ready[%0d]: got %b expected 1", i, in_ready);
      end
      @(posedge clk);
    end
    #1;
    in_valid = 1'b0;
  endtask

  // Called right after the last input handshake edge
  task automatic wait_valid(input int exp_lat);
    int lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin
        vectors++;
        if (busy !== 1'b1 || in_ready !== 1'b0) begin
          miscompares++;
          $display("FAIL compute_flags: busy=%b in_ready=%b expected busy=1 in_ready=0", busy, in_ready);
        end
      end
    end while (out_valid !== 1'b1 && lat < 20);
    vectors++;
    if (lat != exp_lat) begin
      miscompares++;
      $display("FAIL latency: got %0d cycles expected %0d", lat, exp_lat);
    end
  endtask

  task automatic receive_frame(input int stall_k, input int stall_n);
    int   got     = 0;
    int   budget  = 0;
    int   stalled = 0;
    bin_t hold;
    bin_t e;
    while (got < 4 && budget < 100) begin
      @(negedge clk);
      budget++;
      if (out_valid === 1'b1 && got == stall_k && stalled < stall_n) begin
        out_ready = 1'b0;
        if (stalled == 0) begin
          hold.re = out_real; hold.im = out_imag; hold.last = out_last;
        end else begin
          vectors++;
          if (out_real !== hold.re || out_imag !== hold.im || out_last !== hold.last) begin
            miscompares++;
            $display("FAIL stall_hold: got (%0d,%0d,%b) expected (%0d,%0d,%b)",
                     out_real, out_imag, out_last, hold.re, hold.im, hold.last);
          end
        end
        vectors++;
        if (in_ready !== 1'b0) begin
          miscompares++;
          $display("FAIL stall_in_ready: got %b expected 0", in_ready);
        end
        stalled++;
      end else begin
        out_ready = 1'b1;
        if (out_valid === 1'b1) begin
          vectors++;
          if (sb.size() == 0) begin
            miscompares++;
            $display("FAIL extra_bin: got (%0d,%0d) expected none", out_real, out_imag);
          end else begin
            e = sb.pop_front();
            if (out_real !== e.re || out_imag !== e.im || out_last !== e.last) begin
              miscompares++;
              $display("FAIL bin[%0d]: got (%0d,%0d,last=%b) expected (%0d,%0d,last=%b)",
                       got, out_real, out_imag, out_last, e.re, e.im, e.last);
            end
          end
          got++;
        end
      end
    end
    if (got < 4) begin
      vectors++;
      miscompares++;
      $display("FAIL unload_timeout: got %0d bins expected 4", got);
    end
    @(negedge clk);
    out_ready = 1'b0;
    vectors++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL post_frame: out_valid=%b in_ready=%b busy=%b expected 0,1,0",
               out_valid, in_ready, busy);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_real = '0; in_imag = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    vectors++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_last !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_flags: in_ready=%b out_valid=%b out_last=%b busy=%b expected all 0",
               in_ready, out_valid, out_last, busy);
    end
    vectors++;
    if (out_real !== 16'sd0 || out_imag !== 16'sd0) begin
      miscompares++;
      $display("FAIL reset_data: got (%0d,%0d) expected (0,0)", out_real, out_imag);
    end
    reset = 1'b0;
    #1;
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL release_ready: got %b expected 1", in_ready);
    end
  endtask

  task automatic test_ramp(input int stall_k, input int stall_n);
    int xr [4];
    int xi [4];
    xr = '{1, 2, 3, 4};
    xi = '{0, 0, 0, 0};
    push_ramp_expected();
    send_frame(xr, xi);
    wait_valid(5);
    receive_frame(stall_k, stall_n);
  endtask

  task automatic test_impulse();
    int xr [4];
    int xi [4];
    xr = '{100, 0, 0, 0};
    xi = '{-50, 0, 0, 0};
    for (int k = 0; k < 4; k++) push_exp(100, -50, k == 3);
    send_frame(xr, xi);
    wait_valid(5);
    receive_frame(-1, 0);
  endtask

  task automatic test_overflow();
    int xr [4];
    int xi [4];
    xr = '{20000, 20000, 20000, 20000};
    xi = '{0, 0, 0, 0};
    // 80000 mod 2^16
    push_exp(14464, 0, 1'b0);
    push_exp(0, 0, 1'b0);
    push_exp(0, 0, 1'b0);
    push_exp(0, 0, 1'b1);
    send_frame(xr, xi);
    wait_valid(5);
    receive_frame(-1, 0);
  endtask

  task automatic test_random();
    int xr [4];
    int xi [4];
    for (int f = 0; f < 3; f++) begin
      for (int i = 0; i < 4; i++) begin
        xr[i] = int'($urandom_range(65535)) - 32768;
        xi[i] = int'($urandom_range(65535)) - 32768;
      end
      push_dft(xr, xi);
      send_frame(xr, xi);
      wait_valid(5);
      receive_frame(f, 1 + f);
    end
  endtask

  task automatic test_reset_mid();
    int xr [4];
    int xi [4];
    xr = '{9, -7, 5, 3};
    xi = '{1, 2, -3, 4};
    send_frame(xr, xi);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    vectors++;
    if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_reset: in_ready=%b busy=%b out_valid=%b expected 1,0,0",
               in_ready, busy, out_valid);
    end
    test_ramp(-1, 0);
  endtask

  initial begin
    test_reset();
    test_ramp(-1, 0);
    test_ramp(1, 3);
`ifndef FFT_SCALE_EN
    test_impulse();
    test_overflow();
    test_random();
`endif
    test_reset_mid();
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
